// File: rtl/am4_mcseq.sv
// Microprogram sequencer for the M4 microcode ROM: next-address select, uPC,
// LIFO subroutine/loop stack and loop counter, all advancing on the shared ROM enable.
module am4_mcseq #(
    parameter int AW      = 10,
    parameter int SD      = 4,
    parameter int CW      = 8,
    parameter int RST_VEC = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [3:0]    op,
    input  logic          cc,
    input  logic [AW-1:0] ba,
    input  logic [AW-1:0] map,
    output logic [AW-1:0] addr,
    output logic          sp_empty,
    output logic          sp_full,
    output logic          cnt_zero,
    output logic          err
);

    localparam int SPW = $clog2(SD + 1);

    localparam logic [AW-1:0]  RVEC    = AW'(RST_VEC);
    localparam logic [AW-1:0]  A_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  C_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]  C_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [SPW-1:0] S_ZERO  = {SPW{1'b0}};
    localparam logic [SPW-1:0] S_ONE   = {{(SPW-1){1'b0}}, 1'b1};
    localparam logic [SPW-1:0] S_MAX   = SPW'(SD);

    localparam logic [3:0] OP_CONT  = 4'd0;
    localparam logic [3:0] OP_JMP   = 4'd1;
    localparam logic [3:0] OP_CJMP  = 4'd2;
    localparam logic [3:0] OP_CALL  = 4'd3;
    localparam logic [3:0] OP_CCALL = 4'd4;
    localparam logic [3:0] OP_RET   = 4'd5;
    localparam logic [3:0] OP_CRET  = 4'd6;
    localparam logic [3:0] OP_LDCT  = 4'd7;
    localparam logic [3:0] OP_LOOP  = 4'd8;
    localparam logic [3:0] OP_MAP   = 4'd9;
    localparam logic [3:0] OP_PUSH  = 4'd10;
    localparam logic [3:0] OP_POP   = 4'd11;
    localparam logic [3:0] OP_RPT   = 4'd12;

    logic [AW-1:0]  upc_r;
    logic [SPW-1:0] sp_r;
    logic [CW-1:0]  cnt_r;
    logic           err_r;
    logic [AW-1:0]  stk_r [SD];

    logic [AW-1:0]  top_s;
    logic [AW-1:0]  nxt_s;
    logic           push_s;
    logic           pop_s;
    logic           rd_s;
    logic           ld_s;
    logic           dec_s;
    logic           empty_s;
    logic           full_s;
    logic           cnt_nz_s;
    logic           wr_s;
    logic           fault_s;

    assign empty_s  = (sp_r == S_ZERO);
    assign full_s   = (sp_r == S_MAX);
    assign cnt_nz_s = (cnt_r != C_ZERO);

    // Top-of-stack read; an empty stack yields the reset vector
    always_comb begin
        top_s = RVEC;
        for (int i = 0; i < SD; i++) begin
            top_s = (sp_r == SPW'(i + 1)) ? stk_r[i] : top_s;
        end
    end

    // Opcode decode: address source plus stack/counter side effects
    always_comb begin
        nxt_s  = upc_r;
        push_s = 1'b0;
        pop_s  = 1'b0;
        rd_s   = 1'b0;
        ld_s   = 1'b0;
        dec_s  = 1'b0;
        case (op)
            OP_CONT:  nxt_s = upc_r;
            OP_JMP:   nxt_s = ba;
            OP_CJMP:  nxt_s = cc ? ba : upc_r;
            OP_CALL: begin
                nxt_s  = ba;
                push_s = 1'b1;
            end
            OP_CCALL: begin
                nxt_s  = cc ? ba : upc_r;
                push_s = cc;
            end
            OP_RET: begin
                nxt_s = top_s;
                pop_s = 1'b1;
            end
            OP_CRET: begin
                nxt_s = cc ? top_s : upc_r;
                pop_s = cc;
            end
            OP_LDCT:  ld_s = 1'b1;
            OP_LOOP: begin
                if (cnt_nz_s) begin
                    nxt_s = ba;
                    dec_s = 1'b1;
                end else begin
                    nxt_s = upc_r;
                end
            end
            OP_MAP:   nxt_s = map;
            OP_PUSH:  push_s = 1'b1;
            OP_POP:   pop_s = 1'b1;
            OP_RPT: begin
                // Repeat re-enters the loop start without consuming it; the final pass pops it
                if (cnt_nz_s) begin
                    nxt_s = top_s;
                    dec_s = 1'b1;
                    rd_s  = 1'b1;
                end else begin
                    pop_s = 1'b1;
                end
            end
            default:  nxt_s = upc_r;
        endcase
    end

    // Reset forces the fetch vector regardless of the opcode on the ROM bus
    always_comb begin
        if (rst) begin
            addr = RVEC;
        end else begin
            addr = nxt_s;
        end
    end

    assign wr_s    = push_s & ~full_s;
    assign fault_s = (push_s & full_s) | ((pop_s | rd_s) & empty_s);

    // Sequencer state: uPC, stack pointer, loop counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            upc_r <= RVEC + A_ONE;
            sp_r  <= S_ZERO;
            cnt_r <= C_ZERO;
            err_r <= 1'b0;
        end else if (ena) begin
            upc_r <= addr + A_ONE;
            err_r <= err_r | fault_s;
            if (wr_s) begin
                sp_r <= sp_r + S_ONE;
            end else if (pop_s && !empty_s) begin
                sp_r <= sp_r - S_ONE;
            end
            if (ld_s) begin
                cnt_r <= ba[CW-1:0];
            end else if (dec_s) begin
                cnt_r <= cnt_r - C_ONE;
            end
        end
    end

    // Stack storage; contents carry no reset value
    always_ff @(posedge clk) begin
        for (int i = 0; i < SD; i++) begin
            if (!rst && ena && wr_s && (sp_r == SPW'(i))) begin
                stk_r[i] <= upc_r;
            end
        end
    end

    assign sp_empty = empty_s;
    assign sp_full  = full_s;
    assign cnt_zero = ~cnt_nz_s;
    assign err      = err_r;

endmodule

// File: tb/tb_am4_mcseq.sv
// Bench for am4_mcseq: directed scenarios plus random ops, checked against a
// queue-based behavioural model of the sequencer.
module tb_am4_mcseq;

    localparam int AW = 10;
    localparam int SD = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [3:0]    op;
    logic          cc;
    logic [AW-1:0] ba;
    logic [AW-1:0] map;
    logic [AW-1:0] addr;
    logic          sp_empty;
    logic          sp_full;
    logic          cnt_zero;
    logic          err;

    always #5 clk = ~clk;

    am4_mcseq #(.AW(AW), .SD(SD), .CW(CW), .RST_VEC(0)) dut (
        .clk(clk), .rst(rst), .ena(ena), .op(op), .cc(cc), .ba(ba), .map(map),
        .addr(addr), .sp_empty(sp_empty), .sp_full(sp_full),
        .cnt_zero(cnt_zero), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_upc;
    int m_cnt;
    bit m_err;
    int m_stk[$];

    int exp_addr;
    bit exp_empty, exp_full, exp_zero, exp_err;

    function automatic int m_top();
        if (m_stk.size() > 0) return m_stk[m_stk.size()-1];
        else return 0;
    endfunction

    // Drive one microinstruction and predict the outputs for this cycle
    task automatic apply(input logic r, input logic e, input logic [3:0] o,
                         input logic c, input int b, input int m);
        rst = r; ena = e; op = o; cc = c; ba = b[AW-1:0]; map = m[AW-1:0];
        if (r) exp_addr = 0;
        else begin
            case (int'(o))
                1:       exp_addr = int'(ba);
                2:       exp_addr = c ? int'(ba) : m_upc;
                3:       exp_addr = int'(ba);
                4:       exp_addr = c ? int'(ba) : m_upc;
                5:       exp_addr = m_top();
                6:       exp_addr = c ? m_top() : m_upc;
                8:       exp_addr = (m_cnt > 0) ? int'(ba) : m_upc;
                9:       exp_addr = int'(map);
                12:      exp_addr = (m_cnt > 0) ? m_top() : m_upc;
                default: exp_addr = m_upc;
            endcase
        end
        exp_empty = (m_stk.size() == 0);
        exp_full  = (m_stk.size() == SD);
        exp_zero  = (m_cnt == 0);
        exp_err   = m_err;
        @(negedge clk);
    endtask

    // Take the clock edge and update the model with the applied inputs
    task automatic advance();
        int  oc;
        bit  pu, po;
        @(posedge clk);
        if (rst) begin
            m_upc = 1; m_cnt = 0; m_err = 0; m_stk.delete();
        end else if (ena) begin
            oc = m_cnt;
            pu = (op == 4'd3) || (op == 4'd4 && cc) || (op == 4'd10);
            po = (op == 4'd5) || (op == 4'd6 && cc) || (op == 4'd11) || (op == 4'd12 && oc == 0);
            if (op == 4'd12 && oc != 0 && m_stk.size() == 0) m_err = 1;
            if (pu) begin
                if (m_stk.size() >= SD) m_err = 1;
                else m_stk.push_back(m_upc);
            end
            if (po) begin
                if (m_stk.size() == 0) m_err = 1;
                else void'(m_stk.pop_back());
            end
            if (op == 4'd7) m_cnt = int'(ba) % (1 << CW);
            if ((op == 4'd8 || op == 4'd12) && oc != 0) m_cnt = oc - 1;
            m_upc = (exp_addr + 1) % (1 << AW);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b0, 4'd1, 1'b0, 'h155, 0);
            n_checks++;
            if (addr !== 10'h000) begin n_fail++; $display("FAIL reset_addr: got %h want 000", addr); end
            advance();
        end
        apply(1'b0, 1'b1, 4'd0, 1'b0, 0, 0);
        n_checks += 5;
        if (addr !== 10'h001)    begin n_fail++; $display("FAIL post_reset_addr: got %h want 001", addr); end
        if (sp_empty !== 1'b1)   begin n_fail++; $display("FAIL post_reset_empty: got %b want 1", sp_empty); end
        if (sp_full !== 1'b0)    begin n_fail++; $display("FAIL post_reset_full: got %b want 0", sp_full); end
        if (cnt_zero !== 1'b1)   begin n_fail++; $display("FAIL post_reset_cntz: got %b want 1", cnt_zero); end
        if (err !== 1'b0)        begin n_fail++; $display("FAIL post_reset_err: got %b want 0", err); end
        advance();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] want [7] = '{10'h3FE, 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h000, 10'h001};
        logic          en   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            apply(1'b0, en[i], (i == 0) ? 4'd1 : 4'd0, 1'b0, 'h3FE, 0);
            n_checks++;
            if (addr !== want[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, addr, want[i]); end
            advance();
        end
    endtask

    task automatic test_call_ret();
        apply(1'b0, 1'b1, 4'd1, 1'b0, 'h01F, 0); advance();
        apply(1'b0, 1'b1, 4'd3, 1'b0, 'h100, 0);
        n_checks++;
        if (addr !== 10'h100) begin n_fail++; $display("FAIL call_addr: got %h want 100", addr); end
        advance();
        apply(1'b0, 1'b1, 4'd5, 1'b0, 'h3AB, 0);
        n_checks += 2;
        if (addr !== 10'h020)  begin n_fail++; $display("FAIL ret_addr: got %h want 020", addr); end
        if (sp_empty !== 1'b0) begin n_fail++; $display("FAIL call_depth: empty=%b want 0", sp_empty); end
        advance();
        apply(1'b0, 1'b1, 4'd4, 1'b0, 'h200, 0);
        n_checks += 2;
        if (addr !== 10'h021)  begin n_fail++; $display("FAIL ccall_nt_addr: got %h want 021", addr); end
        if (sp_empty !== 1'b1) begin n_fail++; $display("FAIL ret_pop: empty=%b want 1", sp_empty); end
        advance();
        apply(1'b0, 1'b1, 4'd0, 1'b0, 0, 0);
        n_checks++;
        if (sp_empty !== 1'b1) begin n_fail++; $display("FAIL ccall_nt_nopush: empty=%b want 1", sp_empty); end
        advance();
    endtask

    task automatic test_overflow();
        int ret_want [5] = '{'h121, 'h111, 'h101, 'h051, 'h000};
        apply(1'b0, 1'b1, 4'd1, 1'b0, 'h050, 0); advance();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 4'd3, 1'b0, 'h100 + 16*i, 0);
            n_checks++;
            if (int'(addr) !== 'h100 + 16*i) begin n_fail++; $display("FAIL ovf_call[%0d]: got %h want %h", i, addr, 'h100 + 16*i); end
            if (i == 4) begin
                n_checks += 2;
                if (sp_full !== 1'b1) begin n_fail++; $display("FAIL full_after4: got %b want 1", sp_full); end
                if (err !== 1'b0)     begin n_fail++; $display("FAIL err_before_ovf: got %b want 0", err); end
            end
            advance();
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 4'd5, 1'b0, 0, 0);
            n_checks += 2;
            if (int'(addr) !== ret_want[i]) begin n_fail++; $display("FAIL lifo_ret[%0d]: got %h want %h", i, addr, ret_want[i]); end
            if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky[%0d]: got %b want 1", i, err); end
            advance();
        end
        apply(1'b0, 1'b1, 4'd0, 1'b0, 0, 0);
        n_checks += 2;
        if (err !== 1'b1)      begin n_fail++; $display("FAIL err_after_unf: got %b want 1", err); end
        if (sp_empty !== 1'b1) begin n_fail++; $display("FAIL unf_sp: empty=%b want 1", sp_empty); end
        advance();
        apply(1'b1, 1'b1, 4'd0, 1'b0, 0, 0); advance();
    endtask

    task automatic test_loop();
        int taken = 0;
        apply(1'b0, 1'b1, 4'd1, 1'b0, 'h080, 0); advance();
        apply(1'b0, 1'b1, 4'd7, 1'b0, 'h003, 0); advance();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 4'd8, 1'b0, 'h081, 0);
            if (i == 0) begin
                n_checks++;
                if (cnt_zero !== 1'b0) begin n_fail++; $display("FAIL ldct_cnt: cnt_zero=%b want 0", cnt_zero); end
            end
            n_checks++;
            if (int'(addr) !== exp_addr) begin n_fail++; $display("FAIL loop_addr[%0d]: got %h want %h", i, addr, exp_addr); end
            if (addr == 10'h081) taken++;
            advance();
        end
        apply(1'b0, 1'b1, 4'd0, 1'b0, 0, 0);
        n_checks += 2;
        if (taken != 3)        begin n_fail++; $display("FAIL loop_taken: got %0d want 3", taken); end
        if (cnt_zero !== 1'b1) begin n_fail++; $display("FAIL loop_cntz: got %b want 1", cnt_zero); end
        advance();
    endtask

    task automatic test_rpt();
        int reps = 0;
        apply(1'b0, 1'b1, 4'd1, 1'b0, 'h0C0, 0); advance();
        apply(1'b0, 1'b1, 4'd7, 1'b0, 'h002, 0); advance();
        apply(1'b0, 1'b1, 4'd10, 1'b0, 0, 0);
        n_checks++;
        if (addr !== 10'h0C2) begin n_fail++; $display("FAIL push_addr: got %h want 0C2", addr); end
        advance();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 4'd12, 1'b0, 0, 0);
            if (addr == 10'h0C2) reps++;
            if (i == 2) begin
                n_checks++;
                if (addr !== 10'h0C3) begin n_fail++; $display("FAIL rpt_exit: got %h want 0C3", addr); end
            end
            advance();
        end
        apply(1'b0, 1'b1, 4'd0, 1'b0, 0, 0);
        n_checks += 2;
        if (reps != 2)         begin n_fail++; $display("FAIL rpt_reps: got %0d want 2", reps); end
        if (sp_empty !== 1'b1) begin n_fail++; $display("FAIL rpt_pop: empty=%b want 1", sp_empty); end
        advance();
    endtask

    task automatic test_map_cjmp();
        apply(1'b0, 1'b1, 4'd9, 1'b1, 'h111, 'h2A5);
        n_checks++;
        if (addr !== 10'h2A5) begin n_fail++; $display("FAIL map_addr: got %h want 2A5", addr); end
        advance();
        apply(1'b0, 1'b1, 4'd2, 1'b0, 'h040, 0);
        n_checks++;
        if (addr !== 10'h2A6) begin n_fail++; $display("FAIL cjmp_nt: got %h want 2A6", addr); end
        advance();
        apply(1'b0, 1'b1, 4'd2, 1'b1, 'h040, 0);
        n_checks++;
        if (addr !== 10'h040) begin n_fail++; $display("FAIL cjmp_t: got %h want 040", addr); end
        advance();
        apply(1'b0, 1'b1, 4'd7, 1'b0, 'h005, 0); advance();
        apply(1'b0, 1'b1, 4'd14, 1'b1, 'h3AA, 'h155);
        n_checks++;
        if (addr !== 10'h042) begin n_fail++; $display("FAIL rsvd_addr: got %h want 042", addr); end
        advance();
        apply(1'b0, 1'b1, 4'd0, 1'b0, 0, 0);
        n_checks += 4;
        if (addr !== 10'h043)  begin n_fail++; $display("FAIL rsvd_next: got %h want 043", addr); end
        if (cnt_zero !== 1'b0) begin n_fail++; $display("FAIL rsvd_cnt: cnt_zero=%b want 0", cnt_zero); end
        if (sp_empty !== 1'b1) begin n_fail++; $display("FAIL rsvd_sp: empty=%b want 1", sp_empty); end
        if (err !== 1'b0)      begin n_fail++; $display("FAIL rsvd_err: got %b want 0", err); end
        advance();
    endtask

    task automatic test_random();
        logic [3:0] o;
        int         b;
        for (int i = 0; i < 600; i++) begin
            o = 4'($urandom_range(0, 15));
            b = (o == 4'd7) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 1023));
            apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0), o,
                  1'($urandom_range(0, 1)), b, int'($urandom_range(0, 1023)));
            n_checks += 5;
            if (int'(addr) !== exp_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, addr, exp_addr); end
            if (sp_empty !== exp_empty)  begin n_fail++; $display("FAIL rnd_empty[%0d]: got %b want %b", i, sp_empty, exp_empty); end
            if (sp_full !== exp_full)    begin n_fail++; $display("FAIL rnd_full[%0d]: got %b want %b", i, sp_full, exp_full); end
            if (cnt_zero !== exp_zero)   begin n_fail++; $display("FAIL rnd_cntz[%0d]: got %b want %b", i, cnt_zero, exp_zero); end
            if (err !== exp_err)         begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, err, exp_err); end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; op = 4'd0; cc = 1'b0; ba = '0; map = '0;
        m_upc = 1; m_cnt = 0; m_err = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_loop();
        test_rpt();
        test_map_cjmp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/am4_mcseq.md
Name: am4_mcseq

Overview:
- Microprogram sequencer for the M4 microcode ROM.
- Each cycle it computes the next 10-bit microinstruction address from the sequencing fields of the current microinstruction (ROM output), a condition input, a mapping address, an internal uPC, a subroutine stack and a loop counter.
- The address output drives the ROM address input directly. The ROM registers it on the same enabled clock edge, so the new microinstruction appears on the following cycle.

Parameters:
AW, 10, microcode address width
SD, 4, subroutine stack depth (entries)
CW, 8, loop counter width (CW <= AW)
RST_VEC, 0, microaddress fetched on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
ena  in  1  clock enable, shared with the ROM
op  in  4  sequencing opcode field of the current microinstruction
cc  in  1  condition code, already polarity-selected
ba  in  AW  branch/literal address field of the current microinstruction
map  in  AW  mapping address (instruction decode)
addr  out  AW  next microaddress to the ROM, combinational
sp_empty  out  1  stack holds 0 entries
sp_full  out  1  stack holds SD entries
cnt_zero  out  1  loop counter == 0
err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - While rst=1, addr=RST_VEC, independent of op and ena.
  - On a clk edge with rst=1, regardless of ena: upc<=RST_VEC+1, sp<=0, cnt<=0, err<=0.
  - Stack contents are don't-care after reset.
  - Outputs after reset: sp_empty=1, sp_full=0, cnt_zero=1, err=0.
  - Reset mid-subroutine or mid-loop discards all context.
- Hold:
  - ena=0 and rst=0: all registers hold.
  - addr still follows inputs combinationally; the ROM output is held, so addr is stable.
- Enabled edge (ena=1, rst=0):
  - upc <= addr+1, modulo 2^AW, so 0x3FF wraps to 0x000.
  - Stack and counter are updated per op.
- Opcodes. "cont" means addr=upc. "push" means stack[sp]<=upc and sp<=sp+1. "pop" means sp<=sp-1. "top" is stack[sp-1].
  - 0 CONT: cont.
  - 1 JMP: addr=ba.
  - 2 CJMP: cc=1 gives addr=ba, else cont.
  - 3 CALL: addr=ba, push.
  - 4 CCALL: cc=1 acts as CALL, else cont with no push.
  - 5 RET: addr=top, pop.
  - 6 CRET: cc=1 acts as RET, else cont with no pop.
  - 7 LDCT: cnt<=ba[CW-1:0], cont.
  - 8 LOOP:
    - cnt!=0: addr=ba, cnt<=cnt-1.
    - cnt==0: cont, cnt unchanged.
  - 9 MAP: addr=map.
  - 10 PUSH: push, cont. This marks a loop start: the pushed value is the address after PUSH.
  - 11 POP: pop, cont.
  - 12 RPT:
    - cnt!=0: addr=top, cnt<=cnt-1, no pop.
    - cnt==0: pop, cont.
  - 13..15: reserved, decode as CONT, no side effects.
- Stack boundaries:
  - Push with sp==SD (overflow): no write, sp unchanged, err<=1. The address still follows the op (CALL still jumps to ba).
  - Pop with sp==0 (underflow): sp unchanged, err<=1. RET/CRET/RPT-with-cnt!=0 then source addr=RST_VEC.
  - err is cleared only by rst.
- Counter: LOOP/RPT never decrement below 0, so there is no wrap. A loop body executes N+1 times for a loaded count N.
- Everything except rst is sampled only when ena=1. An op with cc is evaluated on the same cycle the op is presented.
- Latency:
  - addr is valid in the cycle its op is present.
  - The target microinstruction is on ROM data one enabled cycle later.
  - There is no extra sequencer pipeline stage.
- Implementation: stack as a register array indexed by sp (width clog2(SD+1)). No RAM inference is required.

Test Plan:
- Reset: rst=1 for 2 cycles with ena=0, op=1, ba=0x155 -> addr=0x000 throughout; after release with op=0, addr=0x001, sp_empty=1, cnt_zero=1, err=0.
- Sequential/wrap: JMP ba=0x3FE, then CONT x2 -> addr sequence 0x3FE, 0x3FF, 0x000; ena=0 for 3 cycles mid-sequence -> upc held, no address advance.
- Call/return: CALL ba=0x100 at uPC 0x020 (addr issued by op at 0x01F), then RET at 0x100 -> addr 0x100, then 0x020, sp back to 0. Also: CCALL with cc=0 -> no push, addr=upc.
- Nested overflow: 5 CALLs with SD=4 -> sp_full=1 after the 4th, the 5th jumps but err=1 and sp=4. Then 4 RETs return in LIFO order, and a 5th RET -> addr=0x000, err stays 1.
- Loop counter:
  - LDCT ba=0x003, then LOOP ba=self, 5 times -> branch taken 3 times (cnt 3,2,1 -> 0), then falls through, cnt_zero=1.
  - PUSH/RPT with count 2 -> body repeated 3 times, then stack popped, sp_empty=1.
- MAP and conditional branches:
  - map=0x2A5, MAP -> addr=0x2A5.
  - CJMP ba=0x040 with cc=0 -> addr=upc; with cc=1 -> addr=0x040.
  - Reserved op 14 -> behaves as CONT, no stack or counter change.
